// File: rtl/regfile_port_sequencer_pkg.sv
// Shared definitions for the register-file port sequencer slice.
// Optional feature macro: RF_WB_FWD_EN (accept writeback while a read response is held).
package regfile_pkg;

  localparam int unsigned RF_AW = 5;
  localparam int unsigned RF_DW = 32;

  // Architectural zero register
  localparam logic [RF_AW-1:0] REG_X0 = 5'd0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE1 = 3'd1,
    ISSUE2 = 3'd2,
    CAP2   = 3'd3,
    RESP   = 3'd4
  } rf_seq_state_e;

endpackage

// File: rtl/regfile_port_sequencer_arb.sv
// Two-way arbiter used while the sequencer sits in IDLE.
// A fairness token remembers that the last grant went to a write, so a read
// that collides with a stream of writes wins the very next collision.
module rf_port_arb
  import regfile_pkg::*;
#(
  parameter int unsigned WB_FIRST = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic wb_valid,
  input  logic rd_valid,
  output logic wb_grant,
  output logic rd_grant
);

  logic token_r;

  // Pick a winner from the two requesters using the token and the tie-break
  always_comb begin
    wb_grant = 1'b0;
    rd_grant = 1'b0;
    if (en) begin
      if (wb_valid && rd_valid) begin
        if (token_r || (WB_FIRST == 32'd0)) begin
          rd_grant = 1'b1;
        end else begin
          wb_grant = 1'b1;
        end
      end else if (wb_valid) begin
        wb_grant = 1'b1;
      end else if (rd_valid) begin
        rd_grant = 1'b1;
      end else begin
        wb_grant = 1'b0;
        rd_grant = 1'b0;
      end
    end else begin
      wb_grant = 1'b0;
      rd_grant = 1'b0;
    end
  end

  // Token is set by a write grant and cleared by a read grant
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      token_r <= 1'b0;
    end else if (wb_grant) begin
      token_r <= 1'b1;
    end else if (rd_grant) begin
      token_r <= 1'b0;
    end else begin
      token_r <= token_r;
    end
  end

endmodule

// File: rtl/regfile_port_sequencer.sv
// Sequences operand reads and writeback writes onto a single-port register
// file with a 1-cycle registered read. Owns x0 semantics (reads return 0,
// writes are dropped).
// Optional feature macro: RF_WB_FWD_EN -- while a read response is held in
// RESP, a writeback is accepted, performed, and forwarded into matching
// operand registers.
module regfile_port_sequencer
  import regfile_pkg::*;
#(
  parameter int unsigned AW       = RF_AW,
  parameter int unsigned DW       = RF_DW,
  parameter int unsigned WB_FIRST = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rd_rsp_valid,
  input  logic          rd_rsp_ready,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_d,
  input  logic [DW-1:0] rf_q
);

  rf_seq_state_e state_r;
  rf_seq_state_e state_nxt_s;
  logic [AW-1:0] rs1_addr_r;
  logic [AW-1:0] rs2_addr_r;
  logic [DW-1:0] rs1_data_r;
  logic [DW-1:0] rs2_data_r;
  logic          arb_en_s;
  logic          wb_grant_s;
  logic          rd_grant_s;

  function automatic logic addr_is_x0(input logic [AW-1:0] a);
    return (a == AW'(REG_X0));
  endfunction

  // Arbitration only happens in IDLE and never while reset is applied
  assign arb_en_s = rstn && (state_r == IDLE);

  rf_port_arb #(
    .WB_FIRST (WB_FIRST)
  ) u_arb (
    .clk      (clk),
    .rstn     (rstn),
    .en       (arb_en_s),
    .wb_valid (wb_valid),
    .rd_valid (rd_req_valid),
    .wb_grant (wb_grant_s),
    .rd_grant (rd_grant_s)
  );

  assign rs1_data = rs1_data_r;
  assign rs2_data = rs2_data_r;

  // Next state plus combinational port/handshake outputs; all forced low in reset
  always_comb begin
    state_nxt_s  = state_r;
    rf_we        = 1'b0;
    rf_addr      = {AW{1'b0}};
    rf_d         = {DW{1'b0}};
    wb_ready     = 1'b0;
    rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0;
    if (rstn) begin
      case (state_r)
        IDLE: begin
          if (wb_grant_s) begin
            wb_ready = 1'b1;
            rf_addr  = wb_addr;
            rf_d     = wb_data;
            rf_we    = !addr_is_x0(wb_addr);
          end else if (rd_grant_s) begin
            rd_req_ready = 1'b1;
            state_nxt_s  = ISSUE1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ISSUE1: begin
          rf_addr     = rs1_addr_r;
          state_nxt_s = ISSUE2;
        end
        ISSUE2: begin
          rf_addr     = rs2_addr_r;
          state_nxt_s = CAP2;
        end
        CAP2: begin
          state_nxt_s = RESP;
        end
        RESP: begin
          rd_rsp_valid = 1'b1;
`ifdef RF_WB_FWD_EN
          if (wb_valid) begin
            wb_ready = 1'b1;
            rf_addr  = wb_addr;
            rf_d     = wb_data;
            rf_we    = !addr_is_x0(wb_addr);
          end else begin
            wb_ready = 1'b0;
          end
`endif
          if (rd_rsp_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RESP;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand addresses latch on request accept; data captures follow the 1-cycle RF latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rs1_addr_r <= {AW{1'b0}};
      rs2_addr_r <= {AW{1'b0}};
      rs1_data_r <= {DW{1'b0}};
      rs2_data_r <= {DW{1'b0}};
    end else begin
      if (rd_grant_s) begin
        rs1_addr_r <= rs1_addr;
        rs2_addr_r <= rs2_addr;
      end
      case (state_r)
        ISSUE2: begin
          rs1_data_r <= addr_is_x0(rs1_addr_r) ? {DW{1'b0}} : rf_q;
        end
        CAP2: begin
          rs2_data_r <= addr_is_x0(rs2_addr_r) ? {DW{1'b0}} : rf_q;
        end
        RESP: begin
`ifdef RF_WB_FWD_EN
          // A write landing while the response is held refreshes matching operands
          if (wb_valid && !addr_is_x0(wb_addr)) begin
            if (wb_addr == rs1_addr_r) begin
              rs1_data_r <= wb_data;
            end
            if (wb_addr == rs2_addr_r) begin
              rs2_data_r <= wb_data;
            end
          end
`endif
        end
        default: begin
          rs1_data_r <= rs1_data_r;
          rs2_data_r <= rs2_data_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Self-checking bench for regfile_port_sequencer with a behavioural register
// file and a transaction-level reference model (register array, pending
// response with due cycle, fairness bit).
module tb_regfile_port_sequencer;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int WB_FIRST = 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic          rd_rsp_valid, rd_rsp_ready;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_d;
  logic [DW-1:0] rf_q;

  always #5 clk = ~clk;

  regfile_port_sequencer #(.AW(AW), .DW(DW), .WB_FIRST(WB_FIRST)) dut (
    .clk(clk), .rstn(rstn),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_d(rf_d), .rf_q(rf_q)
  );

  // Behavioural single-port register file, shares rstn with the sequencer
  logic [DW-1:0] mem [32];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      rf_q <= '0;
    end else if (rf_we) begin
      mem[rf_addr] <= rf_d;
    end else begin
      rf_q <= mem[rf_addr];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_regs [32];
  bit            pend;
  int            due;
  int            cyc;
  bit            tok;
  logic [AW-1:0] exp_a1, exp_a2;
  logic [DW-1:0] exp_d1, exp_d2;
  logic [DW-1:0] last1, last2;
  bit            hs_wb, hs_rd;
  int            we_cnt;
  int            n_assert = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    pend = 0; tok = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model
  task automatic cycle();
    bit idle, exp_wbr, exp_rdr, exp_rv, rsp_hs;
    @(negedge clk);
    idle = !pend;
    exp_rv = pend && (cyc >= due);
    exp_wbr = 0; exp_rdr = 0;
    if (idle) begin
      if (wb_valid && rd_req_valid) begin
        if (tok || WB_FIRST == 0) exp_rdr = 1; else exp_wbr = 1;
      end else if (wb_valid) exp_wbr = 1;
      else if (rd_req_valid) exp_rdr = 1;
    end
`ifdef RF_WB_FWD_EN
    else if (exp_rv) exp_wbr = wb_valid;
`endif
    chk("wb_ready", wb_ready, exp_wbr);
    chk("rd_req_ready", rd_req_ready, exp_rdr);
    chk("rd_rsp_valid", rd_rsp_valid, exp_rv);
    if (exp_rv) begin
      chk("rs1_data", rs1_data, exp_d1);
      chk("rs2_data", rs2_data, exp_d2);
      last1 = rs1_data; last2 = rs2_data;
    end
    if (exp_wbr) begin
      chk("rf_we_wr", rf_we, (wb_addr != 0));
      chk("rf_addr_wr", rf_addr, wb_addr);
      chk("rf_d_wr", rf_d, wb_data);
    end else begin
      chk("rf_we_idle", rf_we, 1'b0);
    end
    if (rf_we === 1'b1) we_cnt++;
    rsp_hs = exp_rv && rd_rsp_ready;
    hs_wb = exp_wbr;
    hs_rd = exp_rdr;
    @(posedge clk);
    if (rsp_hs) pend = 0;
    if (exp_wbr) begin
      if (wb_addr != 0) begin
        ref_regs[wb_addr] = wb_data;
        if (pend && wb_addr == exp_a1) exp_d1 = wb_data;
        if (pend && wb_addr == exp_a2) exp_d2 = wb_data;
      end
      if (idle) tok = 1;
    end
    if (exp_rdr) begin
      pend = 1; due = cyc + 4; tok = 0;
      exp_a1 = rs1_addr; exp_a2 = rs2_addr;
      exp_d1 = (rs1_addr == 0) ? '0 : ref_regs[rs1_addr];
      exp_d2 = (rs2_addr == 0) ? '0 : ref_regs[rs2_addr];
    end
    cyc++;
    #1;
  endtask

  task automatic send_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 0;
    wb_valid = 1; wb_addr = a; wb_data = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle();
      ok = hs_wb;
    end
    wb_valid = 0;
    if (!ok) chk("write_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bit ok = 0;
    rd_req_valid = 1; rs1_addr = a1; rs2_addr = a2;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle();
      ok = hs_rd;
    end
    rd_req_valid = 0;
    if (!ok) chk("read_timeout", 1'b0, 1'b1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rf_we"}, rf_we, 1'b0);
    chk({tag, "_rf_addr"}, rf_addr, '0);
    chk({tag, "_rf_d"}, rf_d, '0);
    chk({tag, "_wb_ready"}, wb_ready, 1'b0);
    chk({tag, "_rd_req_ready"}, rd_req_ready, 1'b0);
    chk({tag, "_rd_rsp_valid"}, rd_rsp_valid, 1'b0);
    chk({tag, "_rs1_data"}, rs1_data, '0);
    chk({tag, "_rs2_data"}, rs2_data, '0);
  endtask

  initial begin
    bit first_seen, first_wb;
    int wr_since_rd;
    rstn = 0; rd_req_valid = 0; rs1_addr = '0; rs2_addr = '0; rd_rsp_ready = 0;
    wb_valid = 1; wb_addr = 5'd3; wb_data = 32'h1; cyc = 0; we_cnt = 0;
    model_reset();
    // Reset state, with a request pending on the input
    repeat (2) @(posedge clk);
    #2 chk_all_zero("reset");
    wb_valid = 0;
    @(posedge clk); #1 rstn = 1;

    // x5 write then read rs1=5, rs2=0
    rd_rsp_ready = 1; we_cnt = 0;
    send_write(5'd5, 32'hDEADBEEF);
    send_read(5'd5, 5'd0);
    run(5);
    chk("x5_rs1", last1, 32'hDEADBEEF);
    chk("x5_rs2", last2, 32'h0);
    chk("x5_we_pulses", we_cnt, 1);

    // x0 write is dropped; read of x0 is zero
    we_cnt = 0;
    send_write(5'd0, 32'h1234);
    send_read(5'd0, 5'd5);
    run(5);
    chk("x0_we_pulses", we_cnt, 0);
    chk("x0_rs1", last1, 32'h0);
    chk("x0_rs2", last2, 32'hDEADBEEF);

    // Both requesters held high: grants alternate, reads never starve
    wb_valid = 1; wb_addr = 5'd1; wb_data = $urandom;
    rd_req_valid = 1; rs1_addr = 5'd1; rs2_addr = 5'd2;
    first_seen = 0; first_wb = 0; wr_since_rd = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!first_seen && (hs_wb || hs_rd)) begin first_seen = 1; first_wb = hs_wb; end
      if (hs_wb) begin
        wr_since_rd++;
        wb_addr = 5'($urandom_range(1, 7)); wb_data = $urandom;
      end
      if (hs_rd) begin
        chk("no_starve", (wr_since_rd <= 1), 1'b1);
        wr_since_rd = 0;
        rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
      end
    end
    chk("first_grant_write", first_wb, 1'b1);
    wb_valid = 0; rd_req_valid = 0;
    run(6);

    // Write arriving during a read waits for IDLE; next read sees it
    send_write(5'd9, 32'hAAAA0009);
    send_read(5'd9, 5'd0);
    send_write(5'd9, 32'hBBBB0009);
    chk("wr_after_rsp", pend, 1'b0);
    send_read(5'd9, 5'd9);
    run(5);
    chk("raw_rs1", last1, 32'hBBBB0009);
    chk("raw_rs2", last2, 32'hBBBB0009);

    // Response stall for 10 cycles, write to rs2 while held
    send_write(5'd7, 32'h11);
    rd_rsp_ready = 0;
    send_read(5'd3, 5'd7);
    run(3);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin wb_valid = 1; wb_addr = 5'd7; wb_data = 32'h55; end
      cycle();
      if (hs_wb) wb_valid = 0;
    end
    chk("stall_valid", rd_rsp_valid, 1'b1);
`ifdef RF_WB_FWD_EN
    chk("fwd_rs2", rs2_data, 32'h55);
`else
    chk("hold_rs2", rs2_data, 32'h11);
`endif
    rd_rsp_ready = 1;
    for (int i = 0; i < 10 && wb_valid; i++) begin
      cycle();
      if (hs_wb) wb_valid = 0;
    end
    chk("stall_wr_done", wb_valid, 1'b0);
    run(2);

    // Reset asserted during ISSUE2 aborts the read
    send_read(5'd1, 5'd2);
    cycle();
    #2 rstn = 0; wb_valid = 1; rd_req_valid = 1;
    #1 chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    model_reset();
    #1 rstn = 1; wb_valid = 0; rd_req_valid = 0;
    run(8);

    // Randomised traffic with addresses concentrated to provoke RAW hits
    for (int i = 0; i < 600; i++) begin
      if (!wb_valid && $urandom_range(0, 2) == 0) begin
        wb_valid = 1; wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      end
      if (!rd_req_valid && $urandom_range(0, 2) == 0) begin
        rd_req_valid = 1;
        rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
      end
      rd_rsp_ready = 1'($urandom_range(0, 1));
      cycle();
      if (hs_wb) wb_valid = 0;
      if (hs_rd) rd_req_valid = 0;
    end
    wb_valid = 0; rd_req_valid = 0; rd_rsp_ready = 1;
    run(8);
    chk("drain_idle", pend, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_port_sequencer.md
Name: regfile_port_sequencer

Overview:
- Sequences and arbitrates the single-port register file, which has one address port, a write enable, and a registered read with 1-cycle latency.
- Two requesters share the port:
  - decode stage: needs rs1 and rs2 operands, with a valid/ready request and a valid/ready response;
  - writeback stage: needs one rd write.
- Sits between the decode/writeback logic and the register file instance.
- Owns x0 semantics: reads of x0 return 0; writes to x0 are dropped.

Parameters:
- AW, 5, register address width.
- DW, 32, register data width.
- WB_FIRST, 1, tie-break when both requesters are valid in IDLE and no fairness token is set: 1 means write wins, 0 means read wins.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- rd_req_valid  in  1  operand read request
- rd_req_ready  out  1  request accepted this cycle
- rs1_addr  in  AW  first operand address
- rs2_addr  in  AW  second operand address
- rd_rsp_valid  out  1  operand data valid
- rd_rsp_ready  in  1  consumer accepts operands
- rs1_data  out  DW  operand 1
- rs2_data  out  DW  operand 2
- wb_valid  in  1  write request
- wb_ready  out  1  write accepted this cycle
- wb_addr  in  AW  write address
- wb_data  in  DW  write data
- rf_we  out  1  register file write enable
- rf_addr  out  AW  register file address
- rf_d  out  DW  register file write data
- rf_q  in  DW  register file read data; valid the cycle after rf_addr is presented with rf_we=0

Behaviour:
- States: IDLE, ISSUE1, ISSUE2, CAP2, RESP.
- Reset:
  - state=IDLE, rs1_data=0, rs2_data=0, fairness token=0;
  - all outputs 0, including rf_we, rf_addr, rf_d, rd_req_ready, wb_ready, rd_rsp_valid.
- rf_we/rf_addr/rf_d and the ready outputs are combinational from state and inputs; data registers are flopped.
- IDLE arbitration:
  - Only wb_valid: wb_ready=1; rf_addr=wb_addr, rf_d=wb_data; rf_we=1 unless wb_addr==0. Stay in IDLE; set token=1.
  - Only rd_req_valid: rd_req_ready=1; latch rs1/rs2 addresses; go to ISSUE1; clear token.
  - Both valid: if token=1, read wins; otherwise WB_FIRST decides. The loser waits.
  - Result: no back-to-back write starvation of reads.
- ISSUE1: rf_addr=rs1, rf_we=0 → ISSUE2.
- ISSUE2: rf_addr=rs2, rf_we=0; capture rs1_data = (rs1==0) ? 0 : rf_q → CAP2.
- CAP2: capture rs2_data = (rs2==0) ? 0 : rf_q → RESP.
- RESP:
  - rd_rsp_valid=1; rs1_data/rs2_data held stable until rd_rsp_ready.
  - On handshake, go to IDLE; no new request is accepted in that cycle.
- Latency: request handshake in cycle T gives rd_rsp_valid in cycle T+4; minimum turnaround per read is 5 cycles.
- Outside IDLE, wb_ready=0 and rd_req_ready=0. The exception is RESP when RF_WB_FWD_EN is defined.
- RAW ordering: a write accepted before a read handshake is visible to that read. Writes are never lost or reordered.
- rs1==rs2 needs no special case: both reads are performed.
- Reset mid-sequence: returns to IDLE immediately and drops the in-flight response. The register file shares rstn.

Optional Feature:
- Macro RF_WB_FWD_EN.
- Defined:
  - In RESP, wb_ready=wb_valid and the write is performed to the register file (x0 still suppressed).
  - If wb_addr matches rs1 or rs2 (nonzero), the matching rsX_data register is updated with wb_data in the same cycle.
  - If that cycle is also the rd_rsp_ready handshake, the consumer sees the pre-write value.
- Undefined: wb_ready=0 in RESP.

Decomposition:
- Package regfile_pkg:
  - RF_AW and RF_DW constants;
  - REG_X0 constant (0);
  - rf_seq_state_e enum (IDLE, ISSUE1, ISSUE2, CAP2, RESP).
- One sub-module: rf_port_arb, the IDLE-state two-way arbiter holding the fairness token and WB_FIRST tie-break.

Test Plan:
- Write x5=0xDEADBEEF, then read rs1=5, rs2=0 → rf_we pulses once with rf_addr=5; response 4 cycles after the read handshake: rs1_data=0xDEADBEEF, rs2_data=0.
- Write x0=0x1234, then read rs1=0 → rf_we stays 0 throughout; rs1_data=0.
- wb_valid and rd_req_valid held high together, WB_FIRST=1 → grants alternate: write, read, write…; the read is never delayed by more than one write.
- Read in progress with wb_valid asserted during ISSUE1..CAP2 → wb_ready=0 until IDLE; the write lands after the response; the next read returns the new value.
- rd_rsp_ready held low for 10 cycles → rd_rsp_valid=1 and data stable for all 10 cycles; with RF_WB_FWD_EN, a write to rs2 (x7=0x55) in RESP updates rs2_data to 0x55.
- rstn asserted during ISSUE2 → all outputs 0 immediately; after release, state is IDLE and rd_rsp_valid is never asserted for the aborted request.
